mac_sequencer: RTL

Sequences one `MacUnit` through a single dot product (one neuron's weighted sum) over `len` input/weight pairs. It issues synchronous-read addresses to the input (x) and weight (w) memories, and drives `mac_acc_loopback` and `mac_acc_update` in step with the returned data. Once the last product is accumulated, it captures the final `acc` into a result register and holds it behind a valid/ready handshake. It sits between the layer controller (which issues `start`) and the `MacUnit`/memory datapath.

---
 rtl/mac_sequencer_pkg.sv | 21 ++
 rtl/mac_sequencer_if.sv | 44 ++++
 rtl/mac_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mac_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// definitions
//   Shared fixed-point format and the mac_sequencer state encoding.
//   Q_INT/Q_FRAC give the MacUnit Q-format; Q_SIZE is the full word width of
//   acc and result.
// -----------------------------------------------------------------------------
package definitions;

    localparam int Q_INT  = 8;
    localparam int Q_FRAC = 8;
    localparam int Q_SIZE = Q_INT + Q_FRAC;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CAPTURE,
        DONE
    } mac_seq_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// mac_sequencer_if
//   Bundles every non-clock signal of the mac_sequencer.
//   Control   : start, len, x_base, w_base (from layer controller), busy
//   Memory    : rd_en, x_addr, w_addr (synchronous-read x/w memories)
//   MacUnit   : mac_acc_loopback, mac_acc_update (to MacUnit), acc (from it)
//   Result    : result, result_valid, result_ready (valid/ready handshake)
//   Modports  : slave  - the sequencer itself
//               master - the surrounding layer engine / testbench
// -----------------------------------------------------------------------------
interface mac_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) ();
    import definitions::*;

    logic                     start;
    logic [LEN_W-1:0]         len;
    logic [ADDR_W-1:0]        x_base;
    logic [ADDR_W-1:0]        w_base;
    logic                     rd_en;
    logic [ADDR_W-1:0]        x_addr;
    logic [ADDR_W-1:0]        w_addr;
    logic                     mac_acc_loopback;
    logic                     mac_acc_update;
    logic signed [Q_SIZE-1:0] acc;
    logic signed [Q_SIZE-1:0] result;
    logic                     result_valid;
    logic                     result_ready;
    logic                     busy;

    modport slave (
        input  start, len, x_base, w_base, acc, result_ready,
        output rd_en, x_addr, w_addr, mac_acc_loopback, mac_acc_update,
               result, result_valid, busy
    );

    modport master (
        output start, len, x_base, w_base, acc, result_ready,
        input  rd_en, x_addr, w_addr, mac_acc_loopback, mac_acc_update,
               result, result_valid, busy
    );

endinterface

// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
//   Walks one MacUnit through a single dot product of len x/w pairs, then
//   captures the final accumulator into a result register held behind a
//   valid/ready handshake.
//   Ports:
//     clk     - single clock, rising edge
//     rst_n   - asynchronous active-low reset
//     seq_bus - mac_sequencer_if.slave (control, memory, MacUnit, result)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module mac_sequencer
    import definitions::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_sequencer_if.slave seq_bus
);

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    mac_seq_state_t           r_state;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_k;
    logic [ADDR_W-1:0]        r_x_addr;
    logic [ADDR_W-1:0]        r_w_addr;
    logic                     r_rd_en;
    logic                     r_upd;
    logic                     r_lb;
    logic signed [Q_SIZE-1:0] r_result;
    logic                     r_valid;
    logic                     r_busy;

    // r_k is the index of the address currently on the bus; the read for the
    // final pair is being issued when it reaches len-1.
    logic w_last;
    assign w_last = (r_k == (r_len - LEN_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_k      <= '0;
            r_x_addr <= '0;
            r_w_addr <= '0;
            r_rd_en  <= 1'b0;
            r_upd    <= 1'b0;
            r_lb     <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // Memory data returns one cycle after the read, so the update
            // strobe is the read strobe delayed by one. Only the element read
            // with k=0 starts a fresh sum; this also hides any stale acc.
            r_upd <= r_rd_en;
            r_lb  <= r_rd_en && (r_k != '0);

            case (r_state)
                IDLE: begin
                    if (seq_bus.start) begin
                        r_busy <= 1'b1;
                        if (seq_bus.len != '0) begin
                            r_len    <= seq_bus.len;
                            r_k      <= '0;
                            r_x_addr <= seq_bus.x_base;
                            r_w_addr <= seq_bus.w_base;
                            r_rd_en  <= 1'b1;
                            r_state  <= RUN;
                        end else begin
                            r_result <= '0;
                            r_valid  <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end

                RUN: begin
                    if (w_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        // Addresses wrap naturally at 2^ADDR_W.
                        r_k      <= r_k + LEN_ONE;
                        r_x_addr <= r_x_addr + ADDR_ONE;
                        r_w_addr <= r_w_addr + ADDR_ONE;
                    end
                end

                // Final update is on the MacUnit this cycle.
                DRAIN: r_state <= CAPTURE;

                CAPTURE: begin
                    r_result <= seq_bus.acc;
                    r_valid  <= 1'b1;
                    r_state  <= DONE;
                end

                DONE: begin
                    if (seq_bus.result_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_rd_en <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign seq_bus.rd_en            = r_rd_en;
    assign seq_bus.x_addr           = r_x_addr;
    assign seq_bus.w_addr           = r_w_addr;
    assign seq_bus.mac_acc_update   = r_upd;
    assign seq_bus.mac_acc_loopback = r_lb;
    assign seq_bus.result           = r_result;
    assign seq_bus.result_valid     = r_valid;
    assign seq_bus.busy             = r_busy;

endmodule
